// File: rtl/pulse_stretch_pkg.sv
// Shared types and sizing helpers for the pulse_stretch_led LED flash stretcher.
package pulse_stretch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ON,
      GAP
   } state_t;

   // The timer only ever holds TICKS-1, so clog2 of the larger phase suffices.
   function automatic int unsigned timer_width(input int unsigned on_ticks,
                                               input int unsigned off_ticks);
      int unsigned m;
      int unsigned w;
      m = (on_ticks > off_ticks) ? on_ticks : off_ticks;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int unsigned pend_max(input int unsigned width);
      return (1 << width) - 1;
   endfunction

endpackage

// File: rtl/pulse_stretch_led_timer.sv
// Loadable down-counter shared by the ON and GAP phases; holds at zero.
module stretch_timer
   import pulse_stretch_pkg::*;
#(
   parameter int unsigned W = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretch_led.sv
// Event-pulse to LED-flash stretcher with pending-event replay.
// Define PULSE_STRETCH_EDGE_DETECT_EN to treat ev_in as a level (rising-edge events).
module pulse_stretch_led
   import pulse_stretch_pkg::*;
#(
   parameter int unsigned ON_TICKS  = 5000000,
   parameter int unsigned OFF_TICKS = 2500000,
   parameter int unsigned PEND_W    = 4
) (
   input  logic              Clk_100M,
   input  logic              rst,
   input  logic              ev_in,
   output logic              led_out,
   output logic              busy,
   output logic [PEND_W-1:0] pend_cnt,
   output logic              ovf
);

   localparam int unsigned     TW       = timer_width(ON_TICKS, OFF_TICKS);
   localparam logic [TW-1:0]   ON_LOAD  = TW'(ON_TICKS - 1);
   localparam logic [TW-1:0]   OFF_LOAD = TW'(OFF_TICKS - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(pend_max(PEND_W));

   state_t            state_q, state_d;
   logic              led_q;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic              tmr_load;
   logic [TW-1:0]     tmr_val;
   logic              tmr_zero;
   logic              ev;
   logic              inc, dec;

`ifdef PULSE_STRETCH_EDGE_DETECT_EN
   logic ev_q, evt_q;

   // Registered rising-edge pulse: one extra cycle of latency by design.
   always_ff @(posedge Clk_100M) begin
      if (rst) begin
         ev_q  <= 1'b0;
         evt_q <= 1'b0;
      end else begin
         ev_q  <= ev_in;
         evt_q <= ev_in & ~ev_q;
      end
   end

   assign ev = evt_q;
`else
   assign ev = ev_in;
`endif

   stretch_timer #(
      .W (TW)
   ) u_timer (
      .clk_i      (Clk_100M),
      .rst_i      (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge Clk_100M) begin
      if (rst) begin
         state_q <= IDLE;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         led_q   <= (state_d == ON);
      end
   end

   // A GAP-exit event counts toward the replay decision even with pend_q==0.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ev) state_d = ON;
         ON:      if (tmr_zero) state_d = GAP;
         GAP:     if (tmr_zero) state_d = ((pend_q != '0) || ev) ? ON : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q != IDLE);
      led_out  = led_q;
      tmr_load = (state_d != state_q) && (state_d != IDLE);
      tmr_val  = (state_d == GAP) ? OFF_LOAD : ON_LOAD;
   end

   assign inc = ev && (state_q != IDLE);
   assign dec = (state_q == GAP) && (state_d == ON);

   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (inc && !dec) begin
         if (pend_q == PEND_MAX) ovf_d = 1'b1;
         else pend_d = pend_q + 1'b1;
      end else if (dec && !inc) begin
         pend_d = pend_q - 1'b1;
      end
   end

   always_ff @(posedge Clk_100M) begin
      if (rst) begin
         pend_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
      end
   end

   assign pend_cnt = pend_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_pulse_stretch_led.sv
// Directed-vector bench for pulse_stretch_led (ON_TICKS=4, OFF_TICKS=2, PEND_W=2).
module tb_pulse_stretch_led;

   localparam int unsigned LEN = 40;

   logic       clk = 1'b0;
   logic       rst;
   logic       ev_in;
   logic       led_out;
   logic       busy;
   logic [1:0] pend_cnt;
   logic       ovf;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic        ev_v   [LEN];
   logic        rst_v  [LEN];
   logic        led_v  [LEN];
   logic        busy_v [LEN];
   logic        ovf_v  [LEN];
   int unsigned pend_v [LEN];

   pulse_stretch_led #(
      .ON_TICKS  (4),
      .OFF_TICKS (2),
      .PEND_W    (2)
   ) dut (
      .Clk_100M (clk),
      .rst      (rst),
      .ev_in    (ev_in),
      .led_out  (led_out),
      .busy     (busy),
      .pend_cnt (pend_cnt),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_vectors();
      for (int i = 0; i < LEN; i++) begin
         ev_v[i]   = 1'b0;
         rst_v[i]  = 1'b0;
         led_v[i]  = 1'b0;
         busy_v[i] = 1'b0;
         ovf_v[i]  = 1'b0;
         pend_v[i] = 0;
      end
   endtask

   task automatic ev_at(input int a, input int b);
      for (int i = a; i <= b; i++) ev_v[i] = 1'b1;
   endtask

   task automatic led_at(input int a, input int b);
      for (int i = a; i <= b; i++) led_v[i] = 1'b1;
   endtask

   task automatic busy_at(input int a, input int b);
      for (int i = a; i <= b; i++) busy_v[i] = 1'b1;
   endtask

   task automatic pend_at(input int a, input int b, input int unsigned v);
      for (int i = a; i <= b; i++) pend_v[i] = v;
   endtask

   task automatic ovf_from(input int a);
      for (int i = a; i < LEN; i++) ovf_v[i] = 1'b1;
   endtask

   task automatic do_reset(input string name);
      rst   = 1'b1;
      ev_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst   = 1'b0;
      ev_in = 1'b0;
      check($sformatf("%s_rst_led", name), led_out, 0);
      check($sformatf("%s_rst_busy", name), busy, 0);
      check($sformatf("%s_rst_pend", name), pend_cnt, 0);
      check($sformatf("%s_rst_ovf", name), ovf, 0);
   endtask

   // Outputs seen at the start of iteration c belong to cycle c; ev_in/rst drive cycle c.
   task automatic run_vectors(input string name);
      do_reset(name);
      for (int c = 0; c < LEN; c++) begin
         check($sformatf("%s_led_c%0d", name, c), led_out, led_v[c]);
         check($sformatf("%s_busy_c%0d", name, c), busy, busy_v[c]);
         check($sformatf("%s_pend_c%0d", name, c), pend_cnt, pend_v[c]);
         check($sformatf("%s_ovf_c%0d", name, c), ovf, ovf_v[c]);
         ev_in = ev_v[c];
         rst   = rst_v[c];
         @(posedge clk);
         #1;
      end
      ev_in = 1'b0;
      rst   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      ev_in = 1'b0;
`ifdef PULSE_STRETCH_EDGE_DETECT_EN
      clear_vectors();
      ev_at(10, 30);
      led_at(12, 15);
      busy_at(12, 17);
      run_vectors("edge");
`else
      clear_vectors();
      ev_at(10, 10);
      led_at(11, 14);
      busy_at(11, 16);
      run_vectors("single");

      clear_vectors();
      ev_at(10, 10);
      ev_at(12, 12);
      led_at(11, 14);
      led_at(17, 20);
      busy_at(11, 22);
      pend_at(13, 16, 1);
      run_vectors("two");

      clear_vectors();
      ev_at(10, 15);
      led_at(11, 14);
      led_at(17, 20);
      led_at(23, 26);
      led_at(29, 32);
      busy_at(11, 34);
      pend_at(12, 12, 1);
      pend_at(13, 13, 2);
      pend_at(14, 16, 3);
      pend_at(17, 22, 2);
      pend_at(23, 28, 1);
      ovf_from(15);
      run_vectors("sat");

      clear_vectors();
      ev_at(10, 10);
      ev_at(12, 12);
      ev_at(16, 16);
      led_at(11, 14);
      led_at(17, 20);
      led_at(23, 26);
      busy_at(11, 28);
      pend_at(13, 22, 1);
      run_vectors("gapexit1");

      clear_vectors();
      ev_at(10, 10);
      ev_at(16, 16);
      led_at(11, 14);
      led_at(17, 20);
      busy_at(11, 22);
      run_vectors("gapexit0");

      clear_vectors();
      ev_at(8, 10);
      ev_at(12, 12);
      rst_v[12] = 1'b1;
      led_at(9, 12);
      busy_at(9, 12);
      pend_at(10, 10, 1);
      pend_at(11, 12, 2);
      run_vectors("midrst");
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pulse_stretch_led.md
Name: pulse_stretch_led

Overview:
- Output-side counterpart to the board pushbutton debounce path: converts single-cycle internal event pulses into human-visible LED flashes.
- Each accepted event produces one LED-on window of ON_TICKS cycles, followed by a mandatory dark gap of OFF_TICKS cycles.
- Events arriving while a flash is in progress are counted and replayed, so none is lost visually until the pending counter saturates.
- Sits between processor/status logic and board LED pins.

Parameters:
- ON_TICKS, 5000000, Clk_100M cycles the LED is held on per event (50 ms at 100 MHz); legal range >= 1.
- OFF_TICKS, 2500000, Clk_100M cycles the LED is held off between consecutive flashes; legal range >= 1.
- PEND_W, 4, width of the pending-event counter; maximum pending = 2^PEND_W - 1.

Ports:
- Clk_100M  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- ev_in  input  1  event request; one event per high cycle (see optional feature for edge mode).
- led_out  output  1  registered LED drive, 1 = lit.
- busy  output  1  high whenever state != IDLE.
- pend_cnt  output  PEND_W  events queued but not yet flashed.
- ovf  output  1  sticky; set when an event is dropped because pend_cnt is at maximum.

Behaviour:
- Interface: one clock (Clk_100M); reset (rst) is synchronous and active-high.
- Reset values: led_out=0, busy=0, pend_cnt=0, ovf=0, state=IDLE, timer=0.
- Reset takes priority over everything, including mid-flash and mid-gap: all pending events are discarded; ev_in in the reset cycle is ignored.
- States and transitions:
  - IDLE: ev_in=1 at cycle N -> ON, timer loaded with ON_TICKS-1, led_out=1 from N+1 (latency 1 cycle).
  - ON: led_out=1; timer decrements each cycle; at timer==0 -> GAP, timer loaded with OFF_TICKS-1, led_out=0 next cycle. LED is lit for exactly ON_TICKS cycles.
  - GAP: led_out=0; timer decrements; at timer==0:
    - if pend_cnt>0 (after this cycle's increment) -> ON, pend_cnt decremented, led_out=1 next cycle;
    - else -> IDLE.
    - GAP always lasts exactly OFF_TICKS cycles.
- Events in ON or GAP: pend_cnt+1, saturating at 2^PEND_W-1. An event arriving while saturated is dropped and sets ovf (cleared only by rst).
- Simultaneous increment and decrement (event on the GAP-exit cycle with pend_cnt>0): pend_cnt unchanged; the new event is counted, not dropped.
- Event on the GAP-exit cycle with pend_cnt==0: it is counted, then immediately consumed -> ON, pend_cnt remains 0.
- Timer width: clog2(max(ON_TICKS, OFF_TICKS)); no wrap — the timer is always reloaded before underflow.

Optional Feature:
- Macro PULSE_STRETCH_EDGE_DETECT_EN.
- Defined: ev_in is treated as a level. It is registered once (reset value 0), and an event is generated only on a 0->1 transition. This adds 1 cycle latency (led_out high at N+2) and lets a held level from the debounce path drive the block directly.
- Undefined: every high cycle of ev_in is a distinct event, as described above.

Decomposition:
- Package pulse_stretch_pkg:
  - state enum (IDLE, ON, GAP);
  - timer-width constant function (clog2-based);
  - PEND_MAX derivation helper.
- One sub-module, stretch_timer: loadable down-counter with load value, load strobe, and zero flag. It is reused for both the ON and GAP phases.
- FSM and pending counter stay in the top module.

Test Plan (ON_TICKS=4, OFF_TICKS=2, PEND_W=2 unless stated):
- Single pulse on ev_in at cycle 10 -> led_out=1 cycles 11-14, 0 cycles 15-16, busy=0 from 17, pend_cnt=0 throughout.
- Pulses at cycles 10 and 12 -> flashes at 11-14 and 17-20; pend_cnt=1 during cycles 13-16, 0 afterwards.
- Five pulses at cycles 11-15 while in ON -> pend_cnt saturates at 3; fourth and fifth dropped, ovf=1 from cycle 15; three further flashes follow.
- Event on the last GAP cycle with pend_cnt=1 -> next ON starts, pend_cnt stays 1.
- rst asserted at cycle 12 (mid-ON, pend_cnt=2) -> cycle 13: led_out=0, pend_cnt=0, ovf=0, busy=0; no replayed flashes.
- With PULSE_STRETCH_EDGE_DETECT_EN: ev_in held high for cycles 10-30 -> exactly one flash, led_out=1 cycles 12-15.
